// File: rtl/imem_bank_if.sv
// imem_bank_if: fetch/load bus between the core side (master) and the instruction memory (slave).
interface imem_bank_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic                  init_busy;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_err;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [BYTES-1:0]      load_strb;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_err;

  modport master (
    input  init_busy, fetch_ready, fetch_valid, fetch_data, fetch_err,
           load_ready, load_err,
    output fetch_req, fetch_addr, load_en, load_addr, load_strb, load_data
  );

  modport slave (
    output init_busy, fetch_ready, fetch_valid, fetch_data, fetch_err,
           load_ready, load_err,
    input  fetch_req, fetch_addr, load_en, load_addr, load_strb, load_data
  );
endinterface

// File: rtl/imem_bank.sv
// imem_bank: word-organised 1R/1W instruction RAM with zero-fill sweep after reset,
// registered byte-addressed fetch port and byte-strobed load port.
// Optional feature macro: IMEM_ALIGN_CHECK_EN (misaligned accesses flagged instead of aliased).
module imem_bank #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_bank_if.slave  bus
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned IDX_W = ADDR_WIDTH - OFFS;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  fetch_valid_q;
  logic [DATA_WIDTH-1:0] fetch_data_q;
  logic                  fetch_err_q;
  logic                  load_err_q;

  logic [IDX_W-1:0]      fetch_idx_c;
  logic [IDX_W-1:0]      load_idx_c;
  logic                  fetch_mis_c;
  logic                  load_mis_c;
  logic                  load_acc_c;

  // Address decode and misalignment detection.
  always_comb begin
    fetch_idx_c = bus.fetch_addr[ADDR_WIDTH-1:OFFS];
    load_idx_c  = bus.load_addr[ADDR_WIDTH-1:OFFS];
`ifdef IMEM_ALIGN_CHECK_EN
    fetch_mis_c = |bus.fetch_addr[OFFS-1:0];
    load_mis_c  = |bus.load_addr[OFFS-1:0];
`else
    fetch_mis_c = 1'b0;
    load_mis_c  = 1'b0;
`endif
    load_acc_c  = bus.load_en && (state_q == READY);
  end

`ifndef IMEM_ALIGN_CHECK_EN
  // Offset bits alias to the containing word when alignment checking is off.
  logic unused_offs;
  assign unused_offs = ^{bus.fetch_addr[OFFS-1:0], bus.load_addr[OFFS-1:0]};
`endif

  // Storage: zero-fill during the sweep, strobed lane writes once ready.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (load_acc_c && !load_mis_c) begin
        for (int i = 0; i < int'(BYTES); i++) begin
          if (bus.load_strb[i]) begin
            mem_q[load_idx_c][8*i +: 8] <= bus.load_data[8*i +: 8];
          end
        end
      end
    end
  end

  // Sweep/ready state machine with registered fetch response and load error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      load_err_q    <= 1'b0;
      if (state_q == INIT) begin
        cnt_q <= cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_q <= READY;
        end
      end else begin
        // Reading mem_q here sees pre-write contents on a same-cycle load.
        if (bus.fetch_req) begin
          fetch_valid_q <= 1'b1;
          fetch_err_q   <= fetch_mis_c;
          fetch_data_q  <= fetch_mis_c ? '0 : mem_q[fetch_idx_c];
        end
        if (bus.load_en && load_mis_c) begin
          load_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.init_busy   = (state_q == INIT);
  assign bus.fetch_ready = (state_q == READY);
  assign bus.load_ready  = (state_q == READY);
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.load_err    = load_err_q;
endmodule

// File: tb/tb_imem_bank.sv
// tb_imem_bank: directed checks of sweep, strobed loads, collisions, streaming, resets and alignment.
module tb_imem_bank;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  imem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run until init_busy drops (bounded); report cycle count and any stray fetch_valid.
  task automatic sweep_wait(output int n, output bit saw);
    n = 0;
    saw = 1'b0;
    while (bus.init_busy === 1'b1 && n < 200) begin
      step();
      n++;
      if (bus.fetch_valid !== 1'b0) saw = 1'b1;
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.load_en = 1'b1;
    bus.load_addr = a;
    bus.load_strb = s;
    bus.load_data = d;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = a;
    step();
    bus.fetch_req = 1'b0;
  endtask

  initial begin
    int n;
    bit saw;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_strb = '0;
    bus.load_data = '0;

    // Reset held three cycles
    rst_n = 1'b0;
    step(); step(); step();
    check("rst_init_busy", 64'(bus.init_busy), 64'd1);
    check("rst_fetch_ready", 64'(bus.fetch_ready), 64'd0);
    check("rst_load_ready", 64'(bus.load_ready), 64'd0);
    check("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    check("rst_fetch_data", 64'(bus.fetch_data), 64'd0);
    check("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
    check("rst_load_err", 64'(bus.load_err), 64'd0);

    // Sweep with a fetch request held: must be ignored
    rst_n = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 8'h40;
    sweep_wait(n, saw);
    bus.fetch_req = 1'b0;
    check("sweep_len", 64'(n), 64'd64);
    check("sweep_no_valid", 64'(saw), 64'd0);
    check("ready_fetch", 64'(bus.fetch_ready), 64'd1);
    check("ready_load", 64'(bus.load_ready), 64'd1);

    // Zeroed memory
    fetch(8'h00);
    check("zero_00_valid", 64'(bus.fetch_valid), 64'd1);
    check("zero_00_data", 64'(bus.fetch_data), 64'h0);
    fetch(8'h7C);
    check("zero_7c_data", 64'(bus.fetch_data), 64'h0);
    fetch(8'hFC);
    check("zero_fc_data", 64'(bus.fetch_data), 64'h0);
    step();
    check("valid_pulse", 64'(bus.fetch_valid), 64'd0);

    // Byte strobes
    load(8'h10, 4'b1111, 32'h12345678);
    load(8'h10, 4'b0101, 32'hAABBCCDD);
    fetch(8'h10);
    check("strb_valid", 64'(bus.fetch_valid), 64'd1);
    check("strb_data", 64'(bus.fetch_data), 64'h12BB56DD);
    step();
    check("data_hold", 64'(bus.fetch_data), 64'h12BB56DD);
    load(8'h10, 4'b0000, 32'hFFFFFFFF);
    fetch(8'h10);
    check("strb_zero_noop", 64'(bus.fetch_data), 64'h12BB56DD);

    // Same-cycle collision: read-before-write
    load(8'h20, 4'hF, 32'h00000013);
    bus.load_en = 1'b1;
    bus.load_addr = 8'h20;
    bus.load_strb = 4'hF;
    bus.load_data = 32'hDEADBEEF;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 8'h20;
    step();
    bus.load_en = 1'b0;
    check("coll_old", 64'(bus.fetch_data), 64'h00000013);
    step();
    bus.fetch_req = 1'b0;
    check("coll_new", 64'(bus.fetch_data), 64'hDEADBEEF);

    // Back-to-back fetches
    load(8'h00, 4'hF, 32'd1);
    load(8'h04, 4'hF, 32'd2);
    load(8'h08, 4'hF, 32'd3);
    bus.fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_addr = 8'(4 * i);
      step();
      check("b2b_valid", 64'(bus.fetch_valid), 64'd1);
      check("b2b_data", 64'(bus.fetch_data), 64'(i + 1));
    end
    bus.fetch_req = 1'b0;
    step();
    check("b2b_end", 64'(bus.fetch_valid), 64'd0);

    // Misalignment
    fetch(8'h06);
    check("mis_f_valid", 64'(bus.fetch_valid), 64'd1);
`ifdef IMEM_ALIGN_CHECK_EN
    check("mis_f_err", 64'(bus.fetch_err), 64'd1);
    check("mis_f_data", 64'(bus.fetch_data), 64'h0);
    load(8'h11, 4'hF, 32'hCAFEF00D);
    check("mis_l_err", 64'(bus.load_err), 64'd1);
    step();
    check("mis_l_err_pulse", 64'(bus.load_err), 64'd0);
    fetch(8'h10);
    check("mis_l_nowrite", 64'(bus.fetch_data), 64'h12BB56DD);
    check("mis_err_clear", 64'(bus.fetch_err), 64'd0);
`else
    check("mis_f_err", 64'(bus.fetch_err), 64'd0);
    check("mis_f_data", 64'(bus.fetch_data), 64'd2);
    load(8'h11, 4'hF, 32'hCAFEF00D);
    check("mis_l_err", 64'(bus.load_err), 64'd0);
    fetch(8'h10);
    check("mis_l_alias", 64'(bus.fetch_data), 64'hCAFEF00D);
    check("mis_err_zero", 64'(bus.fetch_err), 64'd0);
`endif

    // Reset mid-sweep at cycle 30
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("mid_busy", 64'(bus.init_busy), 64'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_busy", 64'(bus.init_busy), 64'd1);
    check("mid_rst_ready", 64'(bus.fetch_ready), 64'd0);
    rst_n = 1'b1;
    sweep_wait(n, saw);
    check("mid_sweep_len", 64'(n), 64'd64);

    // Reload, accept a fetch, then reset: response cancelled and data cleared
    load(8'h20, 4'hF, 32'h55AA55AA);
    fetch(8'h20);
    check("pre_rst_valid", 64'(bus.fetch_valid), 64'd1);
    check("pre_rst_data", 64'(bus.fetch_data), 64'h55AA55AA);
    rst_n = 1'b0;
    step();
    check("op_rst_valid", 64'(bus.fetch_valid), 64'd0);
    check("op_rst_data", 64'(bus.fetch_data), 64'h0);
    rst_n = 1'b1;
    sweep_wait(n, saw);
    check("op_sweep_len", 64'(n), 64'd64);
    check("op_sweep_no_valid", 64'(saw), 64'd0);
    fetch(8'h20);
    check("clr_20", 64'(bus.fetch_data), 64'h0);
    fetch(8'h10);
    check("clr_10", 64'(bus.fetch_data), 64'h0);
    fetch(8'h04);
    check("clr_04", 64'(bus.fetch_data), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_bank.md
# imem_bank

Parametrised instruction memory for the RISC-V core: a word-organised 1-read/1-write RAM with a byte-addressed fetch port and a byte-strobed load port. After reset it runs a zero-fill sweep, then serves registered fetches to the IF stage. In parallel it accepts program writes from the loader/debug path. It replaces the flat combinational program memory.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width of both ports.
- DATA_WIDTH, 32, word width in bits; must be 32 or 64.
- BYTES (localparam), DATA_WIDTH/8, byte lanes per word.
- OFFS (localparam), log2(BYTES), byte-offset bits.
- DEPTH (localparam), 1 << (ADDR_WIDTH-OFFS), words stored.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- init_busy  out  1  high while the zero-fill sweep runs.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_WIDTH  fetch byte address.
- fetch_ready  out  1  fetch can be accepted this cycle.
- fetch_valid  out  1  one-cycle pulse when fetch_data/fetch_err are new.
- fetch_data  out  DATA_WIDTH  fetched word.
- fetch_err  out  1  misaligned fetch; only driven with the macro, else tied 0.
- load_en  in  1  write request.
- load_addr  in  ADDR_WIDTH  write byte address.
- load_strb  in  BYTES  byte-lane enables; bit i selects data[8i+7:8i].
- load_data  in  DATA_WIDTH  write data.
- load_ready  out  1  write can be accepted this cycle.
- load_err  out  1  one-cycle pulse when a misaligned write is dropped; only with the macro, else tied 0.

## Operation
- Word index is addr[ADDR_WIDTH-1:OFFS]. Low OFFS bits are ignored unless the macro is defined.
- State machine has two states, INIT and READY:
  - rst_n=0 at a clock edge: state to INIT, sweep counter to 0.
  - INIT with rst_n=1: write all-zero to word[cnt], then cnt+1.
  - When cnt=DEPTH-1 has been written: move to READY; the counter is not reused.
  - READY: stays in READY until the next reset.
- init_busy=1 in INIT. fetch_ready=load_ready=(state==READY).
- Requests presented in INIT are ignored, with no response and no write.
- A fetch is accepted when fetch_req&&fetch_ready:
  - Next cycle fetch_valid=1 and fetch_data=word[index].
  - fetch_data holds its value until the next accepted fetch.
- A load is accepted when load_en&&load_ready: lanes with load_strb[i]=1 are updated at that edge. load_strb=0 is a legal no-op.
- Load and fetch to the same word in the same cycle: the fetch returns the pre-write contents (read-before-write).
- Load and fetch are independent; both may be accepted every cycle, giving 1 word/cycle sustained on each port.
- Reset mid-sweep or mid-operation:
  - Sweep restarts from word 0.
  - Any pending fetch_valid is cancelled.
  - Memory contents are cleared by the new sweep.

## Timing
- Reset values: init_busy=1, fetch_ready=0, load_ready=0, fetch_valid=0, fetch_data=0, fetch_err=0, load_err=0.
- Sweep takes exactly DEPTH cycles after the first edge with rst_n=1. fetch_ready rises at the following edge.
- Fetch latency: 1 cycle from the accepting edge to fetch_valid.
- Write visibility: a fetch accepted one cycle after a load sees the new data.
- No combinational path from any input to any output.

## Configuration
- IMEM_ALIGN_CHECK_EN defined:
  - Fetch with fetch_addr[OFFS-1:0]!=0 is accepted. Next cycle: fetch_valid=1, fetch_err=1, fetch_data=0.
  - Load with load_addr[OFFS-1:0]!=0 is accepted but writes nothing. Next cycle: load_err=1 for one cycle.
  - An aligned fetch clears fetch_err to 0 on its response.
- IMEM_ALIGN_CHECK_EN not defined:
  - fetch_err=load_err=0 constantly.
  - Low offset bits are ignored; misaligned addresses alias to the containing word.

## Test plan
Defaults for all scenarios: DATA_WIDTH=32, ADDR_WIDTH=8, DEPTH=64.
- Reset sweep: hold rst_n=0 for 3 cycles, then release. Required: init_busy=1 for exactly 64 cycles, then fetch_ready=1. Fetches of 0x00, 0x7C and 0xFC all return 0x00000000.
- Byte strobes: load 0x12345678 at 0x10 with strb=4'b1111, then 0xAABBCCDD at 0x10 with strb=4'b0101. Fetch 0x10 returns 0x12BB56DD one cycle after accept.
- Same-cycle collision: word 0x20 holds 0x00000013. Load 0xDEADBEEF strb=4'hF and fetch 0x20 in the same cycle. Required: fetch returns 0x00000013; a fetch next cycle returns 0xDEADBEEF.
- Back-to-back: fetch 0x00, 0x04, 0x08 on consecutive cycles after loading 1, 2, 3. Required: fetch_valid high for 3 consecutive cycles with data 1, 2, 3.
- Reset mid-operation: pull rst_n low at sweep cycle 30, and again one cycle after a fetch is accepted in READY. Required: sweep restarts with a full 64 cycles; no fetch_valid appears; previously loaded data reads 0.
- Misalignment, with the macro: fetch 0x06 gives fetch_valid=1, fetch_err=1, fetch_data=0. Load at 0x11 gives a load_err pulse and word 0x10 is unchanged. Without the macro: fetch 0x06 returns word 0x04 with fetch_err=0.
